fifo_word_reader: RTL and testbench

FIFO_WORD_READER -- requirements
Module: fifo_word_reader

---
 rtl/fifo_word_reader_if.sv | 26 ++
 rtl/fifo_word_reader.sv | 94 +++++++++
 tb/tb_fifo_word_reader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_reader_if.sv
// Bundle between fifo_word_reader, its upstream byte FIFO and its downstream word consumer.
// The master modport is the reader itself; slave is the surrounding FIFO/consumer side.
interface fifo_word_reader_if #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BYTES_PER_WORD = 3
);
  logic [DATA_WIDTH-1:0]                fifo_data;
  logic                                 fifo_empty;
  logic                                 fifo_read;
  logic                                 flush;
  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_out;
  logic                                 word_valid;
  logic                                 word_ready;
  logic                                 busy;
  logic [15:0]                          word_count;

  modport master (
    input  fifo_data, fifo_empty, flush, word_ready,
    output fifo_read, word_out, word_valid, busy, word_count
  );

  modport slave (
    output fifo_data, fifo_empty, flush, word_ready,
    input  fifo_read, word_out, word_valid, busy, word_count
  );
endinterface

// File: rtl/fifo_word_reader.sv
// Pulls BYTES_PER_WORD entries from a one-cycle-latency FIFO and packs them MS byte first
// into a single word with a valid/ready output register and a handshake counter.
module fifo_word_reader #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BYTES_PER_WORD = 3
) (
  input  logic                clockin,
  input  logic                reset_n,
  fifo_word_reader_if.master  bus
);

  localparam int unsigned WORD_W = DATA_WIDTH * BYTES_PER_WORD;
  localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;

  logic [CNT_W-1:0]  r_collected;
  logic              r_pending;
  logic [WORD_W-1:0] r_asm;
  logic [WORD_W-1:0] r_word_out;
  logic              r_word_valid;
  logic              r_busy;
  logic [15:0]       r_word_count;

  logic [SUM_W-1:0]  w_inflight;
  logic              w_full;
  logic              w_read;
  logic              w_capture;
  logic              w_xfer;
  logic              w_hs;
  logic [CNT_W-1:0]  w_collected_next;
  logic [WORD_W-1:0] w_asm_next;

  // Reads are suppressed in reset so no FIFO entry is popped and then lost.
  assign w_inflight = SUM_W'(r_collected) + SUM_W'(r_pending);
  assign w_full     = (r_collected == CNT_W'(BYTES_PER_WORD));
  assign w_read     = reset_n & ~bus.fifo_empty & ~bus.flush &
                      (w_inflight < SUM_W'(BYTES_PER_WORD));
  assign w_capture  = r_pending & ~bus.flush;
  assign w_xfer     = w_full & ~bus.flush & (~r_word_valid | bus.word_ready);
  assign w_hs       = r_word_valid & bus.word_ready;

  // Capture and transfer never coincide: a pending read implies the assembly is not full.
  always_comb begin
    w_collected_next = r_collected;
    w_asm_next       = r_asm;
    if (bus.flush) begin
      w_collected_next = '0;
      w_asm_next       = '0;
    end else if (w_xfer) begin
      w_collected_next = '0;
      w_asm_next       = '0;
    end else if (w_capture) begin
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
        if (r_collected == CNT_W'(i)) begin
          w_asm_next[DATA_WIDTH*(BYTES_PER_WORD-1-i) +: DATA_WIDTH] = bus.fifo_data;
        end
      end
      w_collected_next = r_collected + CNT_W'(1);
    end
  end

  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      r_collected  <= '0;
      r_pending    <= 1'b0;
      r_asm        <= '0;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_collected <= w_collected_next;
      r_pending   <= w_read;
      r_asm       <= w_asm_next;
      r_busy      <= (w_collected_next != '0) | w_read;
      if (w_xfer) begin
        r_word_out   <= r_asm;
        r_word_valid <= 1'b1;
      end else if (w_hs) begin
        r_word_valid <= 1'b0;
      end
      if (w_hs) begin
        r_word_count <= r_word_count + 16'd1;
      end
    end
  end

  assign bus.fifo_read  = w_read;
  assign bus.word_out   = r_word_out;
  assign bus.word_valid = r_word_valid;
  assign bus.busy       = r_busy;
  assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader: byte packing, latency, backpressure, flush, reset and
// word_count wrap (on a second, 2-byte-per-word instance).
module tb_fifo_word_reader;

  localparam int unsigned DW  = 8;
  localparam int unsigned BPW = 3;
  localparam int unsigned WW  = DW * BPW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_word_reader_if #(.DATA_WIDTH(DW), .BYTES_PER_WORD(BPW)) bus ();
  fifo_word_reader_if #(.DATA_WIDTH(DW), .BYTES_PER_WORD(2))   bus_w ();

  fifo_word_reader #(.DATA_WIDTH(DW), .BYTES_PER_WORD(BPW)) dut (
    .clockin (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  fifo_word_reader #(.DATA_WIDTH(DW), .BYTES_PER_WORD(2)) u_wrap (
    .clockin (clk),
    .reset_n (rst_n),
    .bus     (bus_w)
  );

  // Upstream FIFO model: dataout valid the cycle after an accepted read
  logic [7:0] mem [256];
  logic [7:0] rd_ptr     = 8'd0;
  logic [7:0] wr_ptr     = 8'd0;
  logic       hold_empty = 1'b0;
  logic       w_empty    = 1'b1;

  assign bus.fifo_empty   = hold_empty | (rd_ptr == wr_ptr);
  assign bus_w.fifo_empty = w_empty;
  assign bus_w.fifo_data  = 8'h3C;
  assign bus_w.flush      = 1'b0;

  always @(posedge clk) begin
    if (bus.fifo_read) begin
      bus.fifo_data <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end

  // Protocol monitor sampled on the pre-edge values
  int         rd_empty_viol = 0;
  int         stab_viol     = 0;
  logic       prev_hold     = 1'b0;
  logic [WW-1:0] prev_out   = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (bus.fifo_read && bus.fifo_empty) rd_empty_viol++;
      if (prev_hold && (bus.word_out != prev_out)) stab_viol++;
      prev_hold = bus.word_valid & ~bus.word_ready;
      prev_out  = bus.word_out;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic do_reset(input logic ready);
    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.word_ready = ready;
    hold_empty     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!bus.word_valid && n < max_cyc) begin
      tick();
      n++;
    end
    chk({tag, "_arrive"}, 32'(bus.word_valid), 32'd1);
  endtask

  logic [7:0]    rd_bits, vld_bits, busy_bits;
  logic [WW-1:0] got_word;
  logic [7:0]    ptr0;
  int            hs, cyc;
  logic [15:0]   cnt_ffff;

  initial begin
    bus.flush        = 1'b0;
    bus.word_ready   = 1'b1;
    bus_w.word_ready = 1'b0;
    got_word         = '0;

    // Reset state with a non-empty FIFO: nothing may be read
    rst_n = 1'b0;
    tick();
    push(8'h11); push(8'h22); push(8'h33);
    #1;
    chk("rst_word_out",   32'(bus.word_out),   32'd0);
    chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_word_count", 32'(bus.word_count), 32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_fifo_read",  32'(bus.fifo_read),  32'd0);
    tick();

    // Basic word: 3 back-to-back reads, word valid for one cycle after edge M+1
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      rd_bits[i]   = bus.fifo_read;
      vld_bits[i]  = bus.word_valid;
      busy_bits[i] = bus.busy;
      if (bus.word_valid) got_word = bus.word_out;
      tick();
    end
    chk("t1_read_pattern",  32'(rd_bits),    32'h07);
    chk("t1_valid_pattern", 32'(vld_bits),   32'h20);
    chk("t1_busy_pattern",  32'(busy_bits),  32'h1E);
    chk("t1_word",          32'(got_word),   32'h112233);
    chk("t1_count",         32'(bus.word_count), 32'd1);

    // Backpressure: 7 bytes queued, only 6 may be read while the output is held
    do_reset(1'b0);
    ptr0 = rd_ptr;
    for (int i = 1; i <= 7; i++) push(8'hA0 + 8'(i));
    for (int i = 0; i < 15; i++) tick();
    chk("t2_held_word",  32'(bus.word_out),     32'hA1A2A3);
    chk("t2_held_valid", 32'(bus.word_valid),   32'd1);
    chk("t2_reads",      32'(rd_ptr - ptr0),    32'd6);
    chk("t2_rd_blocked", 32'(bus.fifo_read),    32'd0);
    chk("t2_busy",       32'(bus.busy),         32'd1);
    bus.word_ready = 1'b1;
    tick();
    chk("t2_next_word",  32'(bus.word_out),     32'hA4A5A6);
    chk("t2_valid_kept", 32'(bus.word_valid),   32'd1);
    chk("t2_count_1",    32'(bus.word_count),   32'd1);
    tick();
    chk("t2_valid_clr",  32'(bus.word_valid),   32'd0);
    chk("t2_count_2",    32'(bus.word_count),   32'd2);

    // Flush while the third read is pending
    do_reset(1'b1);
    push(8'h01); push(8'h02); push(8'h03);
    tick(); tick(); tick();
    chk("t3_busy_pending", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t3_busy_flushed", 32'(bus.busy),       32'd0);
    chk("t3_no_word",      32'(bus.word_valid), 32'd0);
    chk("t3_fifo_drained", 32'(rd_ptr),         32'(wr_ptr));
    push(8'h07); push(8'h08); push(8'h09);
    wait_valid("t3", 20);
    chk("t3_word", 32'(bus.word_out), 32'h070809);
    tick();
    chk("t3_count", 32'(bus.word_count), 32'd1);

    // fifo_empty toggling every cycle
    do_reset(1'b1);
    push(8'h5A); push(8'hC3); push(8'h3C);
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          hold_empty = ~hold_empty;
          tick();
        end
        hold_empty = 1'b0;
      end
      begin
        wait_valid("t4", 30);
        got_word = bus.word_out;
      end
    join
    chk("t4_word", 32'(got_word), 32'h5AC33C);

    // Reset mid-word with a read in flight
    do_reset(1'b1);
    push(8'h12); push(8'h34); push(8'h56);
    wait_valid("t5a", 20);
    chk("t5_first_word", 32'(bus.word_out), 32'h123456);
    tick();
    chk("t5_count_pre", 32'(bus.word_count), 32'd1);
    push(8'hDE); push(8'hAD); push(8'hBE);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_word_out", 32'(bus.word_out),   32'd0);
    chk("t5_rst_valid",    32'(bus.word_valid), 32'd0);
    chk("t5_rst_count",    32'(bus.word_count), 32'd0);
    chk("t5_rst_busy",     32'(bus.busy),       32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t5_idle_busy", 32'(bus.busy), 32'd0);
    push(8'h44); push(8'h55); push(8'h66);
    wait_valid("t5b", 20);
    chk("t5_new_word", 32'(bus.word_out), 32'h445566);

    chk("rd_while_empty", 32'(rd_empty_viol), 32'd0);
    chk("hold_stable",    32'(stab_viol),     32'd0);

    // word_count wrap: 65537 handshakes on the 2-byte instance
    do_reset(1'b1);
    w_empty          = 1'b0;
    bus_w.word_ready = 1'b1;
    hs       = 0;
    cyc      = 0;
    cnt_ffff = 16'h0;
    while (hs < 65537 && cyc < 300000) begin
      tick();
      cyc++;
      if (bus_w.word_valid && bus_w.word_ready) begin
        hs++;
        if (hs == 65536) cnt_ffff = bus_w.word_count;
      end
    end
    chk("wrap_word", 32'(bus_w.word_out), 32'h3C3C);
    tick();
    bus_w.word_ready = 1'b0;
    chk("wrap_hs_done", 32'(hs),               32'd65537);
    chk("wrap_ffff",    32'(cnt_ffff),         32'hFFFF);
    chk("wrap_count",   32'(bus_w.word_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
